// File: rtl/mem_req_initiator_pkg.sv
// mem_req_initiator_pkg: shared widths, bus encodings, error codes and FSM states for the memory request initiator
package mem_req_initiator_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W = 2;
  localparam int MEM_ERR_W = 2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd3;
  localparam logic [MEM_ERR_W-1:0] MEM_ERR_OK = 2'd0;
  localparam logic [MEM_ERR_W-1:0] MEM_ERR_MISALIGN = 2'd1;
  localparam logic [MEM_ERR_W-1:0] MEM_ERR_INVALID = 2'd2;
  localparam logic [MEM_ERR_W-1:0] MEM_ERR_TIMEOUT = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  function automatic logic misaligned(input logic [MEM_COUNT_W-1:0] count, input logic [1:0] a);
    return (count == MEM_COUNT_HALF && a[0]) || (count == MEM_COUNT_WORD && a != 2'd0);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement of store data and extraction/extension of load data
module mem_lane_align
  import mem_req_initiator_pkg::*;
(
  input  logic [1:0]             addr_lo,
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic                   sgn,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic [WORD_W-1:0]      rd_word,
  output logic [WORD_W-1:0]      wr_lanes,
  output logic [WORD_W-1:0]      rd_ext
);
  logic [4:0] sh;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] rs;
  assign sh = {addr_lo, 3'b000};
  assign mask = count == MEM_COUNT_BYTE ? 32'h0000_00ff :
                count == MEM_COUNT_HALF ? 32'h0000_ffff :
                count == MEM_COUNT_WORD ? 32'hffff_ffff : 32'h0;
  assign wr_lanes = (wr_data & mask) << sh;
  assign rs = rd_word >> sh;
  assign rd_ext = count == MEM_COUNT_BYTE ? {{24{sgn & rs[7]}}, rs[7:0]} :
                  count == MEM_COUNT_HALF ? {{16{sgn & rs[15]}}, rs[15:0]} :
                  count == MEM_COUNT_WORD ? rs : 32'h0;
endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: issues one aligned load/store on the memory bus, waits for a response code or timeout
module mem_req_initiator
  import mem_req_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic [ADDR_W-1:0]      i_op_addr,
  input  logic [WORD_W-1:0]      i_op_wr_data,
  input  logic                   i_op_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_op_count,
  input  logic                   i_op_signed,
  output logic                   o_done_valid,
  output logic [WORD_W-1:0]      o_done_rd_data,
  output logic [MEM_ERR_W-1:0]   o_done_err,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, rd_q, rd_d, lanes, rd_ext;
  logic wr_en_q, wr_en_d, sgn_q, sgn_d;
  logic [MEM_COUNT_W-1:0] count_q, count_d;
  logic [MEM_ERR_W-1:0] err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle, ok;
  assign idle = state_q == S_IDLE;
  // In IDLE the aligner places the incoming store; in BUSY it extracts the latched load
  mem_lane_align u_align (
    .addr_lo (idle ? i_op_addr[1:0] : addr_q[1:0]),
    .count   (idle ? i_op_count : count_q),
    .sgn     (sgn_q),
    .wr_data (i_op_wr_data),
    .rd_word (i_res_rd_data),
    .wr_lanes(lanes),
    .rd_ext  (rd_ext)
  );
  assign ok = i_res_code == (wr_en_q ? MEM_CODE_WRITE : MEM_CODE_READ);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_en_d = wr_en_q;
    count_d = count_q;
    sgn_d = sgn_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (i_op_valid) begin
        sgn_d = i_op_signed;
        if (i_op_count == MEM_COUNT_NONE || misaligned(i_op_count, i_op_addr[1:0])) begin
          state_d = S_DONE;
          err_d = i_op_count == MEM_COUNT_NONE ? MEM_ERR_INVALID : MEM_ERR_MISALIGN;
          rd_d = '0;
        end else begin
          state_d = S_BUSY;
          addr_d = i_op_addr;
          wdata_d = lanes;
          wr_en_d = i_op_wr_en;
          count_d = i_op_count;
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the timeout edge still counts as a response
        if (i_res_code != MEM_CODE_NONE || cnt_d == CW'(TIMEOUT_CYCLES)) begin
          state_d = S_DONE;
          err_d = i_res_code == MEM_CODE_NONE ? MEM_ERR_TIMEOUT : ok ? MEM_ERR_OK : MEM_ERR_INVALID;
          rd_d = (i_res_code != MEM_CODE_NONE && ok && !wr_en_q) ? rd_ext : '0;
          count_d = MEM_COUNT_NONE;
          wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_d = '0;
        err_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      count_q <= MEM_COUNT_NONE;
      sgn_q <= 1'b0;
      cnt_q <= '0;
      rd_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      count_q <= count_d;
      sgn_q <= sgn_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
  assign o_op_ready = idle;
  assign o_done_valid = state_q == S_DONE;
  assign o_done_rd_data = rd_q;
  assign o_done_err = err_q;
  assign o_req_addr = addr_q;
  assign o_req_wr_data = wdata_q;
  assign o_req_wr_en = wr_en_q;
  assign o_req_count = count_q;
endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator: directed tests of the memory request initiator against a same-cycle responder model
module tb_mem_req_initiator;
  import mem_req_initiator_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_op_valid = 1'b0, i_op_wr_en = 1'b0, i_op_signed = 1'b0;
  logic [31:0] i_op_addr = '0, i_op_wr_data = '0;
  logic [1:0] i_op_count = '0;
  logic o_op_ready, o_done_valid, o_req_wr_en;
  logic [31:0] o_done_rd_data, o_req_addr, o_req_wr_data;
  logic [1:0] o_done_err, o_req_count, i_res_code;
  logic [31:0] i_res_rd_data = '0;
  logic resp_en = 1'b0;
  logic [1:0] resp_code = '0;
  logic [31:0] gpio_state;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign i_res_code = (resp_en && o_req_count != MEM_COUNT_NONE) ? resp_code : MEM_CODE_NONE;

  always @(posedge clk)
    if (reset) gpio_state <= '0;
    else if (o_req_wr_en && o_req_count != MEM_COUNT_NONE && i_res_code == MEM_CODE_WRITE)
      gpio_state <= o_req_wr_data;

  mem_req_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_op_addr(i_op_addr),
    .i_op_wr_data(i_op_wr_data), .i_op_wr_en(i_op_wr_en), .i_op_count(i_op_count),
    .i_op_signed(i_op_signed), .o_done_valid(o_done_valid), .o_done_rd_data(o_done_rd_data),
    .o_done_err(o_done_err), .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
    .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count), .i_res_rd_data(i_res_rd_data),
    .i_res_code(i_res_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one accept edge; returns in cycle N+1
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] c, input logic s);
    i_op_addr = a; i_op_wr_data = d; i_op_wr_en = w; i_op_count = c; i_op_signed = s; i_op_valid = 1'b1;
    tick();
    i_op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (o_req_count !== MEM_COUNT_NONE) begin errors++; $display("FAIL reset_count got %0d exp 0", o_req_count); end
    checks++; if (o_done_valid !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_done_valid); end
    checks++; if (o_req_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", o_req_wr_en); end
    reset = 1'b0;
    tick();
    checks++; if (o_op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_op_ready); end
  endtask

  task automatic test_word_store();
    resp_en = 1'b1; resp_code = MEM_CODE_WRITE;
    issue(32'h0, 32'hdeadbeef, 1'b1, MEM_COUNT_WORD, 1'b0);
    checks++; if (o_req_count !== MEM_COUNT_WORD) begin errors++; $display("FAIL ws_count got %0d exp 3", o_req_count); end
    checks++; if (o_req_wr_data !== 32'hdeadbeef) begin errors++; $display("FAIL ws_data got %h exp deadbeef", o_req_wr_data); end
    checks++; if (o_req_wr_en !== 1'b1) begin errors++; $display("FAIL ws_wr_en got %b exp 1", o_req_wr_en); end
    checks++; if (o_op_ready !== 1'b0 || o_done_valid !== 1'b0) begin errors++; $display("FAIL ws_busy got ready=%b done=%b exp 0 0", o_op_ready, o_done_valid); end
    tick();
    checks++; if (o_done_valid !== 1'b1 || o_done_err !== MEM_ERR_OK) begin errors++; $display("FAIL ws_done got v=%b err=%0d exp 1 0", o_done_valid, o_done_err); end
    checks++; if (o_done_rd_data !== 32'h0) begin errors++; $display("FAIL ws_rd got %h exp 0", o_done_rd_data); end
    checks++; if (o_req_count !== MEM_COUNT_NONE || o_req_wr_en !== 1'b0) begin errors++; $display("FAIL ws_release got cnt=%0d we=%b exp 0 0", o_req_count, o_req_wr_en); end
    checks++; if (gpio_state !== 32'hdeadbeef) begin errors++; $display("FAIL ws_gpio got %h exp deadbeef", gpio_state); end
    tick();
    checks++; if (o_done_valid !== 1'b0 || o_op_ready !== 1'b1) begin errors++; $display("FAIL ws_idle got v=%b rdy=%b exp 0 1", o_done_valid, o_op_ready); end
  endtask

  task automatic test_byte_load();
    resp_en = 1'b1; resp_code = MEM_CODE_READ; i_res_rd_data = 32'h0000_8000;
    issue(32'h1, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b1);
    checks++; if (o_req_addr !== 32'h1 || o_req_count !== MEM_COUNT_BYTE) begin errors++; $display("FAIL bl_req got a=%h c=%0d exp 1 1", o_req_addr, o_req_count); end
    tick();
    checks++; if (o_done_rd_data !== 32'hffffff80 || o_done_err !== MEM_ERR_OK) begin errors++; $display("FAIL bl_signed got %h err=%0d exp ffffff80 0", o_done_rd_data, o_done_err); end
    tick();
    issue(32'h1, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b0);
    tick();
    checks++; if (o_done_rd_data !== 32'h00000080 || o_done_valid !== 1'b1) begin errors++; $display("FAIL bl_unsigned got %h v=%b exp 00000080 1", o_done_rd_data, o_done_valid); end
    tick();
    issue(32'h2, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b1);
    i_res_rd_data = 32'h8001_0000;
    tick();
    checks++; if (o_done_rd_data !== 32'hffff8001) begin errors++; $display("FAIL hl_signed got %h exp ffff8001", o_done_rd_data); end
    tick();
  endtask

  task automatic test_half_store();
    resp_en = 1'b1; resp_code = MEM_CODE_WRITE;
    issue(32'h2, 32'habcd1234, 1'b1, MEM_COUNT_HALF, 1'b0);
    checks++; if (o_req_wr_data !== 32'h12340000 || o_req_count !== MEM_COUNT_HALF) begin errors++; $display("FAIL hs_req got %h c=%0d exp 12340000 2", o_req_wr_data, o_req_count); end
    tick();
    checks++; if (o_done_err !== MEM_ERR_OK || o_done_valid !== 1'b1) begin errors++; $display("FAIL hs_done got err=%0d v=%b exp 0 1", o_done_err, o_done_valid); end
    tick();
  endtask

  task automatic test_misalign_invalid();
    resp_en = 1'b1; resp_code = MEM_CODE_READ; i_res_rd_data = 32'h1234_5678;
    issue(32'h2, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
    checks++; if (o_req_count !== MEM_COUNT_NONE) begin errors++; $display("FAIL ma_count got %0d exp 0", o_req_count); end
    checks++; if (o_done_valid !== 1'b1 || o_done_err !== MEM_ERR_MISALIGN || o_done_rd_data !== 32'h0) begin errors++; $display("FAIL ma_done got v=%b err=%0d rd=%h exp 1 1 0", o_done_valid, o_done_err, o_done_rd_data); end
    tick();
    checks++; if (o_done_valid !== 1'b0 || o_done_err !== 2'd0 || o_op_ready !== 1'b1) begin errors++; $display("FAIL ma_idle got v=%b err=%0d rdy=%b exp 0 0 1", o_done_valid, o_done_err, o_op_ready); end
    issue(32'h1, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b0);
    checks++; if (o_done_err !== MEM_ERR_MISALIGN) begin errors++; $display("FAIL ma_half got err=%0d exp 1", o_done_err); end
    tick();
    issue(32'h0, 32'h0, 1'b0, MEM_COUNT_NONE, 1'b0);
    checks++; if (o_done_valid !== 1'b1 || o_done_err !== MEM_ERR_INVALID || o_req_count !== MEM_COUNT_NONE) begin errors++; $display("FAIL none_cnt got v=%b err=%0d c=%0d exp 1 2 0", o_done_valid, o_done_err, o_req_count); end
    tick();
    resp_code = MEM_CODE_WRITE;
    issue(32'h0, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
    tick();
    checks++; if (o_done_err !== MEM_ERR_INVALID || o_done_rd_data !== 32'h0) begin errors++; $display("FAIL mismatch got err=%0d rd=%h exp 2 0", o_done_err, o_done_rd_data); end
    tick();
    resp_code = MEM_CODE_INVALID;
    issue(32'h0, 32'h5, 1'b1, MEM_COUNT_WORD, 1'b0);
    tick();
    checks++; if (o_done_err !== MEM_ERR_INVALID) begin errors++; $display("FAIL invalid_code got err=%0d exp 2", o_done_err); end
    tick();
  endtask

  task automatic test_timeout();
    resp_en = 1'b0; resp_code = MEM_CODE_READ; i_res_rd_data = 32'hcafe_f00d;
    issue(32'h4, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    checks++; if (o_done_valid !== 1'b0 || o_req_count !== MEM_COUNT_WORD) begin errors++; $display("FAIL to_wait got v=%b c=%0d exp 0 3", o_done_valid, o_req_count); end
    tick();
    checks++; if (o_done_valid !== 1'b1 || o_done_err !== MEM_ERR_TIMEOUT || o_req_count !== MEM_COUNT_NONE) begin errors++; $display("FAIL to_done got v=%b err=%0d c=%0d exp 1 3 0", o_done_valid, o_done_err, o_req_count); end
    tick();
    issue(32'h4, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    resp_en = 1'b1;
    tick();
    checks++; if (o_done_err !== MEM_ERR_OK || o_done_rd_data !== 32'hcafef00d) begin errors++; $display("FAIL to_race got err=%0d rd=%h exp 0 cafef00d", o_done_err, o_done_rd_data); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    resp_en = 1'b0;
    issue(32'h0, 32'h77, 1'b1, MEM_COUNT_WORD, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (o_req_count !== MEM_COUNT_NONE || o_req_wr_en !== 1'b0 || o_done_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got c=%0d we=%b v=%b exp 0 0 0", o_req_count, o_req_wr_en, o_done_valid); end
    reset = 1'b0;
    tick();
    checks++; if (o_done_valid !== 1'b0 || o_op_ready !== 1'b1) begin errors++; $display("FAIL rst_after got v=%b rdy=%b exp 0 1", o_done_valid, o_op_ready); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_misalign_invalid();
    test_timeout();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
